// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, FSM states and the multi-cycle op decode.
// Imported by the EX-stage decoder as well as the ALU itself.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring unsigned divider sharing one set of
// registers; one step per cycle for WIDTH cycles after start.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // part: MUL accumulator / DIV partial remainder
    // opa : MUL multiplicand  / DIV dividend shifting into quotient
    // opb : MUL multiplier    / DIV divisor
    logic [CNT_W-1:0] cnt_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        shifted = {part_q, opa_q[WIDTH-1]};
        diff    = shifted - {1'b0, opb_q};
        part_d  = part_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        if (op_q == OP_MUL) begin
            part_d = part_q + (opb_q[0] ? opa_q : '0);
            opa_d  = opa_q << 1;
            opb_d  = opb_q >> 1;
        end else if (!diff[WIDTH]) begin
            // A zero divisor always takes this branch: quotient all ones, remainder = dividend.
            part_d = diff[WIDTH-1:0];
            opa_d  = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
            part_d = shifted[WIDTH-1:0];
            opa_d  = {opa_q[WIDTH-2:0], 1'b0};
        end
    end

    // done marks the final step; result is the post-step value so it can be registered on that edge.
    assign done   = (cnt_q == CNT_W'(1));
    assign result = (op_q == OP_DIVU) ? opa_d : part_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= OP_MUL;
            part_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else if (start) begin
            cnt_q  <= CNT_W'(WIDTH);
            op_q   <= op;
            part_q <= '0;
            opa_q  <= a;
            opb_q  <= b;
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - 1'b1;
            part_q <= part_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle ops complete in one cycle, MUL/DIVU/REMU
// iterate for WIDTH cycles. Handshake: a transfer happens on a rising edge where valid && ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUOut,
    output logic             zero,
    output logic             busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_e         state, state_next;
    alu_op_e            op;
    logic               accept, is_mc, md_done;
    logic [WIDTH-1:0]   sc_result, md_result;
    logic [SHAMT_W-1:0] shamt;

    assign op       = alu_op_e'(sel);
    assign is_mc    = MULDIV_EN && is_multicycle(op);
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = rd2[SHAMT_W-1:0];

    always_comb begin
        sc_result = rd1 + rd2;
        case (op)
            OP_AND:  sc_result = rd1 & rd2;
            OP_OR:   sc_result = rd1 | rd2;
            OP_XOR:  sc_result = rd1 ^ rd2;
            OP_SUB:  sc_result = rd1 - rd2;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(rd1) < $signed(rd2)};
            OP_SLL:  sc_result = rd1 << shamt;
            OP_SRL:  sc_result = rd1 >> shamt;
            default: sc_result = rd1 + rd2;
        endcase
    end

    if (MULDIV_EN) begin : g_muldiv
        alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (accept && is_mc),
            .op     (op),
            .a      (rd1),
            .b      (rd2),
            .done   (md_done),
            .result (md_result)
        );
    end else begin : g_no_muldiv
        assign md_done   = 1'b0;
        assign md_result = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // An accept out of DONE behaves exactly like one out of IDLE, giving back-to-back issue.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = is_mc ? BUSY : DONE;
        end else begin
            case (state)
                BUSY:    if (md_done) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ALUOut    <= '0;
            zero      <= 1'b1;
        end else begin
            out_valid <= (state_next == DONE);
            busy      <= (state_next == BUSY);
            if (accept && !is_mc) begin
                ALUOut <= sc_result;
                zero   <= (sc_result == '0);
            end else if (state == BUSY && md_done) begin
                ALUOut <= md_result;
                zero   <= (md_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a WIDTH=32 instance with mul/div and a WIDTH=8 instance without,
// each checked through a result queue popped on every output transfer.
module tb_alu_seq;
    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  sel;
    logic [31:0] rd1, rd2, alu_out;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, busy8;
    logic [3:0]  sel8;
    logic [7:0]  rd1_8, rd2_8, alu_out8;

    logic [31:0] exp_q[$];
    logic [7:0]  exp8_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  op_tab [0:11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                   4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};

    alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .rd1(rd1), .rd2(rd2), .out_valid(out_valid), .out_ready(out_ready),
        .ALUOut(alu_out), .zero(zero), .busy(busy)
    );

    alu_seq #(.WIDTH(8), .MULDIV_EN(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .sel(sel8), .rd1(rd1_8), .rd2(rd2_8), .out_valid(out_valid8), .out_ready(out_ready8),
        .ALUOut(alu_out8), .zero(zero8), .busy(busy8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd3:    return a ^ b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd8:    return a * b;
            4'd9:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10:   return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // drivers: called just after a rising edge; return just after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        int n;
        n = 0;
        in_valid = 1'b1; sel = op; rd1 = a; rd2 = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            cycle();
            @(negedge clk);
            n++;
        end
        check("accept", 64'(in_ready), 64'd1);
        if (in_ready) exp_q.push_back(exp);
        cycle();
        in_valid = 1'b0; sel = 4'($urandom); rd1 = $urandom; rd2 = $urandom;
    endtask

    task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp);
        int n;
        n = 0;
        in_valid8 = 1'b1; sel8 = op; rd1_8 = a; rd2_8 = b;
        @(negedge clk);
        while (!in_ready8 && n < 200) begin
            cycle();
            @(negedge clk);
            n++;
        end
        check("accept8", 64'(in_ready8), 64'd1);
        if (in_ready8) exp8_q.push_back(exp);
        cycle();
        in_valid8 = 1'b0; sel8 = 4'($urandom); rd1_8 = 8'($urandom); rd2_8 = 8'($urandom);
    endtask

    // lat = cycles from accept until out_valid; also counts busy cycles and ready-while-busy
    task automatic wait_valid(output int lat, output int nbusy, output int rdy_bad);
        lat = -1; nbusy = 0; rdy_bad = 0;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            @(negedge clk);
            if (busy) begin
                nbusy++;
                if (in_ready) rdy_bad++;
            end
            if (out_valid) lat = k;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size() + exp8_q.size()), 64'd0);
        cycle();
    endtask

    // scoreboards
    always @(negedge clk) begin
        logic [31:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("alu_out", 64'(alu_out), 64'(e));
                check("zero", 64'(zero), 64'(e == 32'd0));
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                check("spurious_out8", 64'(exp8_q.size()), 64'd1);
            end else begin
                e = exp8_q.pop_front();
                check("alu_out8", 64'(alu_out8), 64'(e));
                check("zero8", 64'(zero8), 64'(e == 8'd0));
            end
        end
    end

    initial begin
        int lat, nb, rb;
        logic [3:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0;
        in_valid = 1'b0; sel = '0; rd1 = '0; rd2 = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; sel8 = '0; rd1_8 = '0; rd2_8 = '0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_out", 64'(alu_out), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_zero8", 64'(zero8), 64'd1);
        cycle();

        // single-cycle latency and wrap / zero flag
        send(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        wait_valid(lat, nb, rb);
        check("lat_add", 64'(lat), 64'd1);
        cycle();
        send(4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE);
        wait_valid(lat, nb, rb);
        check("lat_sub", 64'(lat), 64'd1);
        cycle();

        // compare and shifts, back-to-back
        send(4'b0111, 32'h8000_0000, 32'd1, 32'd1);
        send(4'b0101, 32'h8000_0000, 32'h21, 32'h4000_0000);
        send(4'b0100, 32'd1, 32'd31, 32'h8000_0000);
        drain();

        // multiply latency, busy window, no ready while busy
        send(4'b1000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
        wait_valid(lat, nb, rb);
        check("lat_mul", 64'(lat), 64'd33);
        check("busy_cycles_mul", 64'(nb), 64'd32);
        check("ready_in_busy", 64'(rb), 64'd0);
        cycle();

        // divide / remainder including divide by zero
        send(4'b1001, 32'd100, 32'd7, 32'd14);
        send(4'b1010, 32'd100, 32'd7, 32'd2);
        send(4'b1001, 32'd9, 32'd0, 32'hFFFF_FFFF);
        send(4'b1010, 32'd9, 32'd0, 32'd9);
        drain();

        // random mix, including an undefined opcode
        for (int i = 0; i < 16; i++) begin
            op = op_tab[$urandom_range(0, 11)];
            a  = $urandom;
            b  = (op == 4'd9 || op == 4'd10) ? 32'($urandom_range(0, 300)) : $urandom;
            send(op, a, b, model(op, a, b));
        end
        drain();

        // backpressure then back-to-back issue
        out_ready = 1'b0;
        send(4'b0010, 32'd3, 32'd4, 32'd7);
        wait_valid(lat, nb, rb);
        check("lat_bp", 64'(lat), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            @(negedge clk);
            check("bp_hold_out", 64'(alu_out), 64'd7);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        cycle();
        out_ready = 1'b1;
        send(4'b0010, 32'd1, 32'd1, 32'd2);
        @(negedge clk);
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_out", 64'(alu_out), 64'd2);
        cycle();

        // asynchronous reset in the 10th busy cycle of a divide
        send(4'b1001, 32'd1000, 32'd3, 32'd333);
        repeat (9) cycle();
        #2;
        check("busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_alu_out", 64'(alu_out), 64'd0);
        check("arst_zero", 64'(zero), 64'd1);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        cycle();
        send(4'b0010, 32'd2, 32'd2, 32'd4);
        wait_valid(lat, nb, rb);
        check("lat_after_rst", 64'(lat), 64'd1);
        cycle();

        // 8-bit instance without mul/div: MUL decodes as ADD
        send8(4'b1000, 8'd3, 8'd4, 8'd7);
        @(negedge clk);
        check("lat_mul_as_add8", 64'(out_valid8), 64'd1);
        check("busy8", 64'(busy8), 64'd0);
        cycle();
        send8(4'b1001, 8'd9, 8'd3, 8'd12);
        send8(4'b0111, 8'h80, 8'd1, 8'd1);
        send8(4'b0101, 8'h80, 8'd9, 8'h40);
        send8(4'b0110, 8'd3, 8'd5, 8'hFE);
        drain();

        check("q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
